// File: rtl/traffic_phase_ctrl_if.sv
// Shared state encoding and the lamp/demand bus of the traffic phase controller.
// slave: controller side (takes tick_en/req/ped_req, drives light/phase_idx/st/walk); master: peer side.
package traffic_phase_pkg;
    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2,
        S_WALK   = 2'd3
    } state_t;
endpackage

interface traffic_phase_ctrl_if #(
    parameter int N_PHASE = 2
);
    logic                   tick_en;
    logic [N_PHASE-1:0]     req;
    logic                   ped_req;
    logic [3*N_PHASE-1:0]   light;
    logic [2:0]             phase_idx;
    logic [1:0]             st;
    logic                   walk;

    modport master (
        output tick_en, req, ped_req,
        input  light, phase_idx, st, walk
    );

    modport slave (
        input  tick_en, req, ped_req,
        output light, phase_idx, st, walk
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// N-phase demand-actuated traffic controller: GREEN -> YELLOW -> ALL_RED per phase.
// Ports: CLK, RST (async high), bus.slave {tick_en, req, ped_req in; light, phase_idx, st, walk out}.
// Optional pedestrian WALK state enabled by defining PED_WALK_EN.
module traffic_phase_ctrl
    import traffic_phase_pkg::*;
#(
    parameter int N_PHASE  = 2,
    parameter int TW       = 8,
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 10,
    parameter int WALK_T   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    traffic_phase_ctrl_if.slave  bus
);

    localparam logic [TW-1:0] G_LAST = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] R_LAST = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] W_LAST = TW'(WALK_T - 1);

    state_t               st_q, st_n;
    logic [2:0]           ph_q, ph_n;
    logic [TW-1:0]        cnt_q, cnt_n;
    logic [N_PHASE-1:0]   req_lat_q, req_lat_n;
    logic [3*N_PHASE-1:0] light_q, light_n;
    logic                 walk_q, walk_n;
    logic                 ped_lat_q, ped_lat_n;
    logic                 bad_st, bad_ph;
    logic [TW-1:0]        last;
    logic [N_PHASE-1:0]   clr;

    // Lamp pattern for a given state/phase; only the served phase may leave red.
    function automatic logic [3*N_PHASE-1:0] lamps(
        input state_t     s,
        input logic [2:0] p
    );
        logic [3*N_PHASE-1:0] l;
        for (int i = 0; i < N_PHASE; i++) begin
            l[3*i +: 3] = 3'b100;
            if (int'(p) == i) begin
                if (s == S_GREEN)
                    l[3*i +: 3] = 3'b001;
                else if (s == S_YELLOW)
                    l[3*i +: 3] = 3'b010;
            end
        end
        return l;
    endfunction

    // Round-robin search starting after p; p itself is checked last.
    // With no demand pending this falls back to p+1.
    function automatic logic [2:0] pick_next(
        input logic [2:0]         p,
        input logic [N_PHASE-1:0] lat
    );
        logic [2:0] r;
        logic       hit;
        int         idx;
        r   = (int'(p) == N_PHASE - 1) ? 3'd0 : p + 3'd1;
        hit = 1'b0;
        for (int k = 1; k <= N_PHASE; k++) begin
            idx = int'(p) + k;
            if (idx >= N_PHASE)
                idx = idx - N_PHASE;
            if (!hit && lat[idx]) begin
                r   = 3'(idx);
                hit = 1'b1;
            end
        end
        return r;
    endfunction

`ifdef PED_WALK_EN
    assign bad_st = 1'b0;
`else
    assign bad_st = (st_q == S_WALK);
`endif
    assign bad_ph = (int'(ph_q) >= N_PHASE);

    always_comb begin
        last = G_LAST;
        case (st_q)
            S_GREEN:  last = G_LAST;
            S_YELLOW: last = Y_LAST;
            S_ALLRED: last = R_LAST;
            S_WALK:   last = W_LAST;
            default:  last = G_LAST;
        endcase
    end

    always_comb begin
        st_n  = st_q;
        ph_n  = ph_q;
        cnt_n = cnt_q;
        if (bad_st || bad_ph) begin
            // Corrupted state: park everything red on a known phase.
            st_n  = S_ALLRED;
            ph_n  = 3'd0;
            cnt_n = '0;
        end else if (bus.tick_en) begin
            if (cnt_q == last) begin
                cnt_n = '0;
                case (st_q)
                    S_GREEN:  st_n = S_YELLOW;
                    S_YELLOW: st_n = S_ALLRED;
                    S_ALLRED: begin
`ifdef PED_WALK_EN
                        if (ped_lat_q) begin
                            st_n = S_WALK;
                        end else begin
                            st_n = S_GREEN;
                            ph_n = pick_next(ph_q, req_lat_q);
                        end
`else
                        st_n = S_GREEN;
                        ph_n = pick_next(ph_q, req_lat_q);
`endif
                    end
                    S_WALK: begin
                        st_n = S_GREEN;
                        ph_n = pick_next(ph_q, req_lat_q);
                    end
                    default: st_n = S_ALLRED;
                endcase
            end else begin
                cnt_n = cnt_q + TW'(1);
            end
        end
    end

    // Entry clear is applied after the OR so it beats a same-cycle request.
    always_comb begin
        clr = '0;
        if (st_n == S_GREEN && st_q != S_GREEN)
            clr[ph_n] = 1'b1;
        req_lat_n = (req_lat_q | bus.req) & ~clr;
    end

`ifdef PED_WALK_EN
    assign ped_lat_n = (st_n == S_WALK && st_q != S_WALK) ?
                       1'b0 : (ped_lat_q | bus.ped_req);
    assign walk_n    = (st_n == S_WALK);
`else
    logic unused_ped;
    assign unused_ped = bus.ped_req ^ ped_lat_q;
    assign ped_lat_n  = 1'b0;
    assign walk_n     = 1'b0;
`endif

    assign light_n = lamps(st_n, ph_n);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q      <= S_GREEN;
            ph_q      <= 3'd0;
            cnt_q     <= '0;
            req_lat_q <= '0;
            ped_lat_q <= 1'b0;
            light_q   <= lamps(S_GREEN, 3'd0);
            walk_q    <= 1'b0;
        end else begin
            st_q      <= st_n;
            ph_q      <= ph_n;
            cnt_q     <= cnt_n;
            req_lat_q <= req_lat_n;
            ped_lat_q <= ped_lat_n;
            light_q   <= light_n;
            walk_q    <= walk_n;
        end
    end

    assign bus.light     = light_q;
    assign bus.phase_idx = ph_q;
    assign bus.st        = st_q;
    assign bus.walk      = walk_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with N_PHASE=3, GREEN_T=4, YELLOW_T=2, ALLRED_T=1.
// Covers rotation, demand skip, latch clear priority, tick freeze, async reset, illegal state.
module tb_traffic_phase_ctrl;
    import traffic_phase_pkg::*;

    localparam int N = 3;

    logic CLK;
    logic RST;
    int   n_tests;
    int   n_fail;

    traffic_phase_ctrl_if #(.N_PHASE(N)) bus ();

    traffic_phase_ctrl #(
        .N_PHASE (N),
        .TW      (8),
        .GREEN_T (4),
        .YELLOW_T(2),
        .ALLRED_T(1),
        .WALK_T  (3)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    localparam logic [8:0] L_G0 = 9'b100_100_001;
    localparam logic [8:0] L_Y0 = 9'b100_100_010;
    localparam logic [8:0] L_G1 = 9'b100_001_100;
    localparam logic [8:0] L_Y1 = 9'b100_010_100;
    localparam logic [8:0] L_G2 = 9'b001_100_100;
    localparam logic [8:0] L_AR = 9'b100_100_100;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk_out(input string tag, input logic [8:0] l,
                           input logic [2:0] p, input logic [1:0] s);
        check({tag, ".light"}, 32'(bus.light), 32'(l));
        check({tag, ".ph"}, 32'(bus.phase_idx), 32'(p));
        check({tag, ".st"}, 32'(bus.st), 32'(s));
    endtask

    // At most one phase may be non-red, and every triple must be a legal lamp.
    always @(negedge CLK) begin
        int nr;
        int ok;
        nr = 0;
        ok = 1;
        for (int i = 0; i < N; i++) begin
            if (bus.light[3*i +: 3] != 3'b100) nr++;
            if (!(bus.light[3*i +: 3] inside {3'b100, 3'b010, 3'b001})) ok = 0;
        end
        check("safety.nonred_le1", 32'(nr <= 1), 32'd1);
        check("safety.legal", 32'(ok), 32'd1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST = 1'b1;
        bus.tick_en = 1'b1;
        bus.req = '0;
        bus.ped_req = 1'b0;
        step(2);
        RST = 1'b0;

        chk_out("reset", L_G0, 3'd0, 2'd0);
        check("reset.cnt", 32'(dut.cnt_q), 32'd0);
        check("reset.walk", 32'(bus.walk), 32'd0);
        step(3);
        chk_out("g0_end", L_G0, 3'd0, 2'd0);
        step(1);
        chk_out("y0", L_Y0, 3'd0, 2'd1);
        step(2);
        chk_out("ar0", L_AR, 3'd0, 2'd2);
        step(1);
        chk_out("g1", L_G1, 3'd1, 2'd0);
        step(7);
        chk_out("g2", L_G2, 3'd2, 2'd0);
        step(7);
        chk_out("g0_wrap", L_G0, 3'd0, 2'd0);

        bus.req = 3'b100;
        step(1);
        bus.req = 3'b000;
        check("skip.lat2", 32'(dut.req_lat_q), 32'h4);
        step(6);
        chk_out("skip.g2", L_G2, 3'd2, 2'd0);
        check("skip.latclr", 32'(dut.req_lat_q), 32'h0);
        step(6);
        chk_out("ar2", L_AR, 3'd2, 2'd2);
        bus.req = 3'b001;
        step(1);
        bus.req = 3'b000;
        chk_out("fallback.g0", L_G0, 3'd0, 2'd0);
        check("clrwins.lat", 32'(dut.req_lat_q), 32'h0);
        step(7);
        chk_out("clrwins.g1", L_G1, 3'd1, 2'd0);

        step(4);
        chk_out("y1", L_Y1, 3'd1, 2'd1);
        step(1);
        bus.tick_en = 1'b0;
        check("freeze.cnt0", 32'(dut.cnt_q), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("freeze.light", 32'(bus.light), 32'(L_Y1));
            check("freeze.cnt", 32'(dut.cnt_q), 32'd1);
        end
        bus.tick_en = 1'b1;
        step(1);
        chk_out("freeze.ar1", L_AR, 3'd1, 2'd2);
        step(1);
        chk_out("g2b", L_G2, 3'd2, 2'd0);

        step(2);
        #2;
        RST = 1'b1;
        #1;
        chk_out("async_rst", L_G0, 3'd0, 2'd0);
        step(1);
        RST = 1'b0;

        step(2);
        force dut.st_q = S_WALK;
        #1;
        release dut.st_q;
        step(1);
        chk_out("bad_st", L_AR, 3'd0, 2'd2);
        step(1);
        chk_out("bad_st.recover", L_G1, 3'd1, 2'd0);
        step(1);
        force dut.ph_q = 3'd5;
        #1;
        release dut.ph_q;
        step(1);
        chk_out("bad_ph", L_AR, 3'd0, 2'd2);

`ifdef PED_WALK_EN
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        step(1);
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        step(4);
        chk_out("ped.ar0", L_AR, 3'd0, 2'd2);
        step(1);
        chk_out("ped.walk", L_AR, 3'd0, 2'd3);
        check("ped.walk_on", 32'(bus.walk), 32'd1);
        step(2);
        check("ped.walk_hold", 32'(bus.walk), 32'd1);
        step(1);
        chk_out("ped.g1", L_G1, 3'd1, 2'd0);
        check("ped.walk_off", 32'(bus.walk), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
